// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Machine-mode trap / CSR controller that sits in the Execute stage, directly
//   after the ID/EX register. It holds mstatus (MIE/MPIE), mie (MTIE/MEIE),
//   mtvec, mepc and mcause. It takes external/timer interrupts at the
//   instruction in E and executes mret. On either event it flushes IF/ID and
//   ID/EX and redirects Fetch in the same cycle. After each redirect the
//   controller blocks new traps, mret and CSR writes for DRAIN_CYCLES cycles
//   while the pipeline refills.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   ValidE     in   1  E holds a real instruction (0 = bubble)
//   PCE        in  32  PC of the instruction in E
//   returnE    in   1  instruction in E is mret
//   CsrEnE     in   1  instruction in E is a CSR op
//   funct3E    in   3  001 CSRRW, 010 CSRRS, 011 CSRRC, others no-op
//   CsrAddrE   in  12  CSR address
//   CsrWdataE  in  32  rs1 operand (already forwarded)
//   ext_irq    in   1  level external interrupt
//   timer_irq  in   1  level timer interrupt
//   CsrRdataE  out 32  old value of the addressed CSR (combinational)
//   Int_flush  out  1  flush IF/ID and ID/EX (combinational)
//   PCRedirect out  1  Fetch selects RedirectPC (combinational)
//   RedirectPC out 32  trap target or mepc (combinational)
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidE,
  input  logic [31:0] PCE,
  input  logic        returnE,
  input  logic        CsrEnE,
  input  logic [2:0]  funct3E,
  input  logic [11:0] CsrAddrE,
  input  logic [31:0] CsrWdataE,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] CsrRdataE,
  output logic        Int_flush,
  output logic        PCRedirect,
  output logic [31:0] RedirectPC
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam int               CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_drain_cnt;
  logic             r_mstatus_mie;
  logic             r_mstatus_mpie;
  logic             r_mie_mtie;
  logic             r_mie_meie;
  logic [31:0]      r_mtvec;
  logic [31:0]      r_mepc;
  logic [31:0]      r_mcause;

  logic             w_idle;
  logic             w_ext_take;
  logic             w_tmr_take;
  logic             w_take_irq;
  logic             w_mret;
  logic             w_csr_op;
  logic             w_csr_we;
  logic [4:0]       w_cause;
  logic [31:0]      w_tvec_base;
  logic [31:0]      w_trap_pc;
  logic [31:0]      w_rdata;
  logic [31:0]      w_new;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_ext_take = ext_irq & r_mie_meie;
  assign w_tmr_take = timer_irq & r_mie_mtie;
  assign w_take_irq = w_idle & ValidE & r_mstatus_mie & (w_ext_take | w_tmr_take);
  // External wins over timer when both are enabled and pending.
  assign w_cause    = w_ext_take ? 5'd11 : 5'd7;
  assign w_mret     = w_idle & ValidE & returnE & ~w_take_irq;
  assign w_csr_op   = (funct3E == 3'b001) | (funct3E == 3'b010) | (funct3E == 3'b011);
  // A trap or mret in the same cycle squashes the CSR write.
  assign w_csr_we   = w_idle & ValidE & CsrEnE & w_csr_op & ~w_take_irq & ~w_mret;

  assign w_tvec_base = {r_mtvec[31:2], 2'b00};
  assign w_trap_pc   = (r_mtvec[1:0] == 2'b01) ? (w_tvec_base + {25'd0, w_cause, 2'b00})
                                               : w_tvec_base;

  // Read mux; mip reflects the interrupt lines as seen this cycle.
  always_comb begin
    w_rdata = 32'h0;
    case (CsrAddrE)
      A_MSTATUS: w_rdata = {24'h0, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000};
      A_MIE:     w_rdata = {20'h0, r_mie_meie, 3'b000, r_mie_mtie, 7'h0};
      A_MTVEC:   w_rdata = r_mtvec;
      A_MEPC:    w_rdata = r_mepc;
      A_MCAUSE:  w_rdata = r_mcause;
      A_MIP:     w_rdata = {20'h0, ext_irq, 3'b000, timer_irq, 7'h0};
      default:   w_rdata = 32'h0;
    endcase
  end

  always_comb begin
    w_new = w_rdata;
    case (funct3E[1:0])
      2'b01:   w_new = CsrWdataE;
      2'b10:   w_new = w_rdata | CsrWdataE;
      2'b11:   w_new = w_rdata & ~CsrWdataE;
      default: w_new = w_rdata;
    endcase
  end

  assign CsrRdataE  = w_rdata;
  assign Int_flush  = ~rst & (w_take_irq | w_mret);
  assign PCRedirect = ~rst & (w_take_irq | w_mret);
  assign RedirectPC = rst        ? 32'h0 :
                      w_take_irq ? w_trap_pc :
                      w_mret     ? r_mepc : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_drain_cnt    <= '0;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mtvec        <= RESET_MTVEC;
      r_mepc         <= 32'h0;
      r_mcause       <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_irq) begin
            // The interrupted instruction is squashed and re-executed after mret.
            r_mepc         <= PCE;
            r_mcause       <= {1'b1, 26'd0, w_cause};
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_state        <= ST_DRAIN;
            r_drain_cnt    <= DRAIN_LOAD;
          end else if (w_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
            r_state        <= ST_DRAIN;
            r_drain_cnt    <= DRAIN_LOAD;
          end else if (w_csr_we) begin
            case (CsrAddrE)
              A_MSTATUS: begin
                r_mstatus_mie  <= w_new[3];
                r_mstatus_mpie <= w_new[7];
              end
              A_MIE: begin
                r_mie_mtie <= w_new[7];
                r_mie_meie <= w_new[11];
              end
              A_MTVEC:  r_mtvec  <= w_new;
              A_MEPC:   r_mepc   <= {w_new[31:2], 2'b00};
              A_MCAUSE: r_mcause <= w_new;
              default: ;
            endcase
          end
        end
        default: begin
          // Counter loaded with DRAIN_CYCLES-1, so exactly DRAIN_CYCLES cycles are blocked.
          if (r_drain_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap/CSR controller in the Execute stage, directly downstream of the ID/EX pipeline register.
- Consumes PCE, returnE, funct3E and the CSR fields the ID/EX register delivers.
- Owns mstatus/mie/mip/mtvec/mepc/mcause.
- Takes external/timer interrupts at the instruction in E, executes mret, and drives Int_flush plus a PC redirect back to Fetch and to the ID/EX register.

Parameters:
- RESET_MTVEC, 32'h0000_0100, reset value of mtvec.
- DRAIN_CYCLES, 2, cycles after a trap or mret during which no new trap/mret is accepted (pipeline refill).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- ValidE  input  1  E holds a real instruction (0 for flushed bubbles)
- PCE  input  32  PC of the instruction in E
- returnE  input  1  instruction in E is mret
- CsrEnE  input  1  instruction in E is a CSR op
- funct3E  input  3  001 CSRRW, 010 CSRRS, 011 CSRRC; others are no-ops
- CsrAddrE  input  12  CSR address
- CsrWdataE  input  32  rs1 operand, already forwarded
- ext_irq  input  1  level external interrupt
- timer_irq  input  1  level timer interrupt
- CsrRdataE  output  32  old CSR value, combinational
- Int_flush  output  1  flush IF/ID and ID/EX, combinational
- PCRedirect  output  1  select RedirectPC in Fetch, combinational
- RedirectPC  output  32  trap target or mepc, combinational

Behaviour:
- Reset (rst=1 at posedge):
  - mstatus.MIE=0, MPIE=0, mie=0, mepc=0, mcause=0, mtvec=RESET_MTVEC.
  - FSM=IDLE, drain counter=0.
  - Int_flush/PCRedirect/RedirectPC are 0 while rst is high.
  - rst during DRAIN aborts it.
- CSR map. Unimplemented addresses read 0 and ignore writes.
  - mstatus 0x300: only bit3 MIE and bit7 MPIE are stored; others read 0.
  - mie 0x304: bit7 MTIE and bit11 MEIE.
  - mtvec 0x305: all 32 bits stored. Mode = bits[1:0]; 01 = vectored, anything else = direct.
  - mepc 0x341: bits[1:0] forced 0 on write.
  - mcause 0x342: full 32 bits.
  - mip 0x344: read-only. bit7 = timer_irq, bit11 = ext_irq, as sampled this cycle.
- CSR write:
  - Commits at posedge when FSM=IDLE, ValidE=1, CsrEnE=1, funct3E in {001,010,011}, and no trap is taken that cycle.
  - new = CSRRW: wdata; CSRRS: old|wdata; CSRRC: old&~wdata.
  - CSRRS/CSRRC with wdata=0 still reads but writes back an unchanged value.
- Interrupt take condition, evaluated combinationally in IDLE:
  - take_irq = ValidE & MIE & ((ext_irq&MEIE) | (timer_irq&MTIE)).
  - Priority: external (cause 11) over timer (cause 7).
- Same-cycle response when take_irq=1:
  - Int_flush=1, PCRedirect=1.
  - RedirectPC = {mtvec[31:2],2'b00} in direct mode; {mtvec[31:2],2'b00} + 4*cause in vectored mode.
- At the posedge after take_irq:
  - mepc<=PCE; the squashed instruction re-executes after mret.
  - mcause<={1'b1,31'(cause)}.
  - MPIE<=MIE, MIE<=0.
  - FSM->DRAIN, counter<=DRAIN_CYCLES-1.
- mret (IDLE, ValidE=1, returnE=1, take_irq=0):
  - Same cycle: Int_flush=1, PCRedirect=1, RedirectPC=mepc.
  - At posedge: MIE<=MPIE, MPIE<=1, FSM->DRAIN.
- Priority when events coincide in one cycle: interrupt > mret > CSR write.
  - Interrupt with mret: mepc=PC of the mret, which is re-executed later.
  - Interrupt with CSR write: write suppressed, rdata ignored downstream.
  - mret with CSR op is impossible by decode; mret wins.
- DRAIN:
  - Int_flush=0, PCRedirect=0.
  - take_irq, mret and CSR writes are all ignored.
  - Counter decrements each cycle; at 0 the FSM returns to IDLE on the next edge.
  - DRAIN_CYCLES=1 means exactly one blocked cycle.
- Level interrupts held high are re-taken only after the handler sets MIE or after mret restores it, and only once IDLE is reached.

Test Plan:
- Reset with mtvec default: write mtvec=0x200, mie=0x800, mstatus=0x8 via CSRRW; assert ext_irq with ValidE=1, PCE=0x40 → same cycle Int_flush=1, RedirectPC=0x200. Next cycle: mepc=0x40, mcause=0x8000000B, mstatus=0x80, then 2 blocked cycles.
- Vectored mode: mtvec=0x201, timer_irq only, MTIE=1 → RedirectPC=0x21C (0x200+4*7), mcause=0x80000007.
- ext_irq and timer_irq together → cause 11 taken. After mret (RedirectPC=mepc, MIE restored to 1) with timer still high and DRAIN finished → timer trap taken, cause 7.
- Interrupt in the same cycle as CSRRW mie=0 → trap taken, mie unchanged. Interrupt with returnE=1 → trap wins, mepc=PCE of the mret.
- CSRRS mstatus wdata=0x88 then CSRRC wdata=0x08 → reads 0x0, 0x88, then mstatus=0x80. Write mepc=0x123 → reads 0x120. Read of 0x7C0 → 0.
- ValidE=0 (bubble) with an enabled pending irq → no trap. rst asserted during DRAIN → next cycle FSM IDLE, all CSRs at reset values.
